// File: rtl/ir_nec_tx_pkg.sv
// +----------------------------------------------------------------------+
// | ir_nec_pkg : state encoding and NEC unit-count constants              |
// | IR_REPEAT_EN adds the repeat-code states.                             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package ir_nec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LEAD_MARK  = 4'd1,
    ST_LEAD_SPACE = 4'd2,
    ST_BIT_MARK   = 4'd3,
    ST_BIT_SPACE  = 4'd4,
    ST_STOP_MARK  = 4'd5,
    ST_GAP        = 4'd6
`ifdef IR_REPEAT_EN
    ,
    ST_REP_MARK   = 4'd7,
    ST_REP_SPACE  = 4'd8,
    ST_REP_STOP   = 4'd9
`endif
  } nec_state_e;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned REP_MARK_U   = 16;
  localparam int unsigned REP_SPACE_U  = 4;
  localparam int unsigned FRAME_U      = 192;

  function automatic logic is_mark(nec_state_e s);
    case (s)
      ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK: return 1'b1;
`ifdef IR_REPEAT_EN
      ST_REP_MARK, ST_REP_STOP:                return 1'b1;
`endif
      default:                                 return 1'b0;
    endcase
  endfunction

  // Index of the final unit in a state; GAP is timed by the frame counter instead.
  function automatic logic [4:0] last_unit_idx(nec_state_e s, logic one_bit);
    case (s)
      ST_LEAD_MARK:  return 5'(LEAD_MARK_U - 1);
      ST_LEAD_SPACE: return 5'(LEAD_SPACE_U - 1);
      ST_BIT_SPACE:  return one_bit ? 5'(ONE_SPACE_U - 1) : 5'(ZERO_SPACE_U - 1);
`ifdef IR_REPEAT_EN
      ST_REP_MARK:   return 5'(REP_MARK_U - 1);
      ST_REP_SPACE:  return 5'(REP_SPACE_U - 1);
`endif
      default:       return 5'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_nec_tx_if.sv
// +----------------------------------------------------------------------+
// | ir_nec_tx_if : request/status bundle between host PIO and NEC sender  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface ir_nec_tx_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       hold;
  logic       busy;
  logic       done;
  logic       env;
  logic       oIR;

  modport master (
    output start, addr, cmd, hold,
    input  busy, done, env, oIR
  );

  modport slave (
    input  start, addr, cmd, hold,
    output busy, done, env, oIR
  );
endinterface

`default_nettype wire

// File: rtl/ir_nec_tx_carrier_gen.sv
// +----------------------------------------------------------------------+
// | ir_carrier_gen : 38 kHz carrier counter with clear and enable         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ir_carrier_gen #(
  parameter int unsigned CARRIER_CYCLES = 1316,
  parameter int unsigned CARRIER_HIGH   = 438
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic carrier_o
);

  localparam int unsigned CW = (CARRIER_CYCLES > 1) ? $clog2(CARRIER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CARRIER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(CARRIER_HIGH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (!clear_i && enable_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Look-ahead level: the phase the counter enters on this edge, so the
  // caller can register envelope and carrier together without skew.
  assign carrier_o = (cnt_d < CNT_HIGH);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ir_nec_tx.sv
// +----------------------------------------------------------------------+
// | ir_nec_tx : NEC infrared frame transmitter with 38 kHz modulation     |
// | Optional repeat codes when IR_REPEAT_EN is defined.  Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES    = 28125,
  parameter int unsigned CARRIER_CYCLES = 1316,
  parameter int unsigned CARRIER_HIGH   = 438
) (
  input  logic        Clk,
  input  logic        Rst_n,
  ir_nec_tx_if.slave  nec
);

  localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYCLES - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAME_U - 1);

  nec_state_e    state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [4:0]    dur_q, dur_d;
  logic [7:0]    frame_q, frame_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [4:0]    bit_q, bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          env_q, env_d;
  logic          oir_q, oir_d;

  logic tick;
  logic state_end;
  logic car_clear;
  logic carrier;

  assign tick      = (state_q != ST_IDLE) && (unit_q == UNIT_LAST);
  assign state_end = tick && ((state_q == ST_GAP) ? (frame_q == FRAME_LAST)
                                                  : (dur_q == last_unit_idx(state_q, shreg_q[0])));

`ifndef IR_REPEAT_EN
  logic unused_hold;
  assign unused_hold = nec.hold;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unit_d  = (state_q == ST_IDLE || tick) ? '0 : unit_q + 1'b1;
    dur_d   = tick ? (state_end ? 5'd0 : dur_q + 5'd1) : dur_q;
    frame_d = tick ? frame_q + 8'd1 : frame_q;

    case (state_q)
      ST_IDLE: begin
        if (nec.start) begin
          state_d = ST_LEAD_MARK;
          shreg_d = {~nec.cmd, nec.cmd, ~nec.addr, nec.addr};
          bit_d   = 5'd0;
          frame_d = 8'd0;
          busy_d  = 1'b1;
        end
      end
      ST_LEAD_MARK:  if (state_end) state_d = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (state_end) state_d = ST_BIT_MARK;
      ST_BIT_MARK:   if (state_end) state_d = ST_BIT_SPACE;
      ST_BIT_SPACE: begin
        if (state_end) begin
          shreg_d = {1'b0, shreg_q[31:1]};
          if (bit_q == 5'd31) begin
            bit_d   = 5'd0;
            state_d = ST_STOP_MARK;
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = ST_BIT_MARK;
          end
        end
      end
      ST_STOP_MARK:  if (state_end) state_d = ST_GAP;
      ST_GAP: begin
        if (state_end) begin
          frame_d = 8'd0;
`ifdef IR_REPEAT_EN
          if (nec.hold) begin
            state_d = ST_REP_MARK;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef IR_REPEAT_EN
      ST_REP_MARK:   if (state_end) state_d = ST_REP_SPACE;
      ST_REP_SPACE:  if (state_end) state_d = ST_REP_STOP;
      ST_REP_STOP:   if (state_end) state_d = ST_GAP;
`endif
      default:       state_d = ST_IDLE;
    endcase

    env_d     = is_mark(state_d);
    car_clear = env_d && (state_d != state_q);
    oir_d     = env_d && carrier;
  end

  ir_carrier_gen #(
    .CARRIER_CYCLES (CARRIER_CYCLES),
    .CARRIER_HIGH   (CARRIER_HIGH)
  ) u_carrier (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .clear_i   (car_clear),
    .enable_i  (env_d),
    .carrier_o (carrier)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      unit_q  <= '0;
      dur_q   <= 5'd0;
      frame_q <= 8'd0;
      shreg_q <= 32'd0;
      bit_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      oir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      dur_q   <= dur_d;
      frame_q <= frame_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      env_q   <= env_d;
      oir_q   <= oir_d;
    end
  end

  assign nec.busy = busy_q;
  assign nec.done = done_q;
  assign nec.env  = env_q;
  assign nec.oIR  = oir_q;

endmodule

`default_nettype wire
